// File: rtl/cpa_pkg.sv
// Shared defaults and stage-count helpers for the pipelined Kogge-Stone carry network.
package cpa_pkg;

  localparam int CPA_BIT_LEN          = 17;
  localparam int CPA_LEVELS_PER_STAGE = 2;

  function automatic int cpa_levels(input int bit_len);
    return $clog2(bit_len);
  endfunction

  function automatic int cpa_num_stages(input int bit_len, input int lps);
    return (cpa_levels(bit_len) + lps - 1) / lps;
  endfunction

  // Index of the last prefix level evaluated inside register stage 'stage'.
  function automatic int cpa_group_end(input int stage, input int lps, input int levels);
    int last;
    last = (stage + 1) * lps;
    if (last > levels) last = levels;
    return last - 1;
  endfunction

endpackage

// File: rtl/cpa_prefix_level.sv
// One combinational Kogge-Stone prefix level combining (G,P) with the pair DIST bits below.
module cpa_prefix_level
  import cpa_pkg::*;
#(
  parameter int BIT_LEN = CPA_BIT_LEN,
  parameter int DIST    = 1
) (
  input  logic [BIT_LEN-1:0] i_g,
  input  logic [BIT_LEN-1:0] i_p,
  output logic [BIT_LEN-1:0] o_g,
  output logic [BIT_LEN-1:0] o_p
);

  always_comb begin
    o_g = i_g;
    o_p = i_p;
    for (int i = DIST; i < BIT_LEN; i++) begin
      o_g[i] = i_g[i] | (i_p[i] & i_g[i-DIST]);
      o_p[i] = i_p[i] & i_p[i-DIST];
    end
  end

endmodule

// File: rtl/cpa_prefix_pipe.sv
// Pipelined parallel-prefix CPA carry network with valid/ready handshake.
// Define CPA_PREFIX_SKID_EN to add a one-entry input skid so in_ready is registered.
module cpa_prefix_pipe
  import cpa_pkg::*;
#(
  parameter int BIT_LEN          = CPA_BIT_LEN,
  parameter int LEVELS_PER_STAGE = CPA_LEVELS_PER_STAGE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] g,
  input  logic [BIT_LEN-1:0] p,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] sum,
  output logic               cout
);

  localparam int LEVELS     = cpa_levels(BIT_LEN);
  localparam int NUM_STAGES = cpa_num_stages(BIT_LEN, LEVELS_PER_STAGE);
  localparam int MID_STAGES = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  typedef struct packed {
    logic [BIT_LEN-1:0] G;
    logic [BIT_LEN-1:0] P;
    logic [BIT_LEN-1:0] p_orig;
    logic               cin;
    logic               valid;
  } gp_stage_t;

  // Carry into bit i is G[i-1]; bit 0 sees cin directly.
  function automatic logic [BIT_LEN-1:0] f_sum(input logic [BIT_LEN-1:0] p_orig,
                                               input logic [BIT_LEN-1:0] g_pre,
                                               input logic             c_in);
    return {p_orig[BIT_LEN-1:1] ^ g_pre[BIT_LEN-2:0], p_orig[0] ^ c_in};
  endfunction

  logic               w_advance;
  logic [BIT_LEN-1:0] w_src_g;
  logic [BIT_LEN-1:0] w_src_p;
  logic               w_src_cin;
  logic               w_src_vld;
  gp_stage_t          w_entry;
  gp_stage_t          w_stage_in [NUM_STAGES];
  logic [BIT_LEN-1:0] w_lv_g [LEVELS];
  logic [BIT_LEN-1:0] w_lv_p [LEVELS];
  logic [BIT_LEN-1:0] w_lo_g [LEVELS];
  logic [BIT_LEN-1:0] w_lo_p [LEVELS];
  logic [BIT_LEN-1:0] w_grp_g [NUM_STAGES];
  logic [BIT_LEN-1:0] w_grp_p [MID_STAGES];

  gp_stage_t          r_st [MID_STAGES];
  logic               r_out_vld;
  logic [BIT_LEN-1:0] r_sum;
  logic               r_cout;

  assign w_advance = !r_out_vld || out_ready;

`ifdef CPA_PREFIX_SKID_EN
  logic               r_skid_full;
  logic [BIT_LEN-1:0] r_skid_g;
  logic [BIT_LEN-1:0] r_skid_p;
  logic               r_skid_cin;

  assign in_ready  = !r_skid_full;
  assign w_src_g   = r_skid_full ? r_skid_g   : g;
  assign w_src_p   = r_skid_full ? r_skid_p   : p;
  assign w_src_cin = r_skid_full ? r_skid_cin : cin;
  assign w_src_vld = r_skid_full || in_valid;

  // A parked item always drains on the next advance, ahead of any new input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid_full <= 1'b0;
      r_skid_g    <= '0;
      r_skid_p    <= '0;
      r_skid_cin  <= 1'b0;
    end else if (w_advance) begin
      r_skid_full <= 1'b0;
    end else if (in_valid && !r_skid_full) begin
      r_skid_full <= 1'b1;
      r_skid_g    <= g;
      r_skid_p    <= p;
      r_skid_cin  <= cin;
    end
  end
`else
  assign in_ready  = w_advance;
  assign w_src_g   = g;
  assign w_src_p   = p;
  assign w_src_cin = cin;
  assign w_src_vld = in_valid;
`endif

  // Entry: fold cin into the bit-0 generate.
  always_comb begin
    w_entry        = '0;
    w_entry.G      = {w_src_g[BIT_LEN-1:1], w_src_g[0] | (w_src_p[0] & w_src_cin)};
    w_entry.P      = {w_src_p[BIT_LEN-1:1], w_src_p[0] & w_src_cin};
    w_entry.p_orig = w_src_p;
    w_entry.cin    = w_src_cin;
    w_entry.valid  = w_src_vld;
  end

  assign w_stage_in[0] = w_entry;

  genvar s, k;
  generate
    for (s = 1; s < NUM_STAGES; s++) begin : g_stage_in
      assign w_stage_in[s] = r_st[s-1];
    end

    for (k = 0; k < LEVELS; k++) begin : g_level
      if (k % LEVELS_PER_STAGE == 0) begin : g_from_reg
        assign w_lv_g[k] = w_stage_in[k / LEVELS_PER_STAGE].G;
        assign w_lv_p[k] = w_stage_in[k / LEVELS_PER_STAGE].P;
      end else begin : g_from_comb
        assign w_lv_g[k] = w_lo_g[k-1];
        assign w_lv_p[k] = w_lo_p[k-1];
      end

      cpa_prefix_level #(
        .BIT_LEN (BIT_LEN),
        .DIST    (1 << k)
      ) u_level (
        .i_g (w_lv_g[k]),
        .i_p (w_lv_p[k]),
        .o_g (w_lo_g[k]),
        .o_p (w_lo_p[k])
      );
    end

    for (s = 0; s < NUM_STAGES; s++) begin : g_group_out
      assign w_grp_g[s] = w_lo_g[cpa_group_end(s, LEVELS_PER_STAGE, LEVELS)];
    end

    for (s = 0; s < NUM_STAGES - 1; s++) begin : g_group_p
      assign w_grp_p[s] = w_lo_p[cpa_group_end(s, LEVELS_PER_STAGE, LEVELS)];
    end
  endgenerate

  // Register stage boundaries: intermediate groups, then the final sum/cout register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MID_STAGES; i++) r_st[i] <= '0;
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else if (w_advance) begin
      for (int i = 0; i < NUM_STAGES - 1; i++) begin
        r_st[i].G      <= w_grp_g[i];
        r_st[i].P      <= w_grp_p[i];
        r_st[i].p_orig <= w_stage_in[i].p_orig;
        r_st[i].cin    <= w_stage_in[i].cin;
        r_st[i].valid  <= w_stage_in[i].valid;
      end
      r_out_vld <= w_stage_in[NUM_STAGES-1].valid;
      r_sum     <= f_sum(w_stage_in[NUM_STAGES-1].p_orig, w_grp_g[NUM_STAGES-1],
                         w_stage_in[NUM_STAGES-1].cin);
      r_cout    <= w_grp_g[NUM_STAGES-1][BIT_LEN-1];
    end
  end

  assign out_valid = r_out_vld;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_cpa_prefix_pipe.sv
// Directed-vector bench for cpa_prefix_pipe (BIT_LEN=17, 3 stages), with streaming scoreboard.
module tb_cpa_prefix_pipe;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0] sb_q [$];

  // Hand-computed {cout,sum} = A + B + cin
  logic [W-1:0] va [10] = '{17'h1FFFF, 17'h00000, 17'h00000, 17'h12345, 17'h10000,
                            17'h0F0F0, 17'h1AAAA, 17'h00000, 17'h1FFFF, 17'h08000};
  logic [W-1:0] vb [10] = '{17'h00001, 17'h1FFFF, 17'h1FFFF, 17'h0ABCD, 17'h10000,
                            17'h10F0F, 17'h15555, 17'h00000, 17'h1FFFF, 17'h08000};
  logic         vc [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [W:0]   ve [10] = '{18'h20000, 18'h20000, 18'h1FFFF, 18'h1CF12, 18'h20001,
                            18'h20000, 18'h2FFFF, 18'h00001, 18'h3FFFF, 18'h10000};

  always #5 clk = ~clk;

  cpa_prefix_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g         (g),
    .p         (p),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    g   = a & b;
    p   = a ^ b;
    cin = c;
  endtask

  task automatic single_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic [W:0] e);
    out_ready = 1'b1;
    set_ab(a, b, c);
    in_valid = 1'b1;
    #1;
    check({tag, "_inrdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check({tag, "_vld_c1"}, out_valid, 0);
    tick();
    check({tag, "_vld_c2"}, out_valid, 0);
    tick();
    check({tag, "_vld_c3"}, out_valid, 1);
    check({tag, "_sum"}, sum, e[W-1:0]);
    check({tag, "_cout"}, cout, e[W]);
    tick();
  endtask

  // mode 0: full rate; mode 1: out_ready low for cycles 8..12; mode 2: random valid/ready
  task automatic run_stream(input string tag, input int n_items, input int mode);
    int           sent;
    int           got;
    int           cyc;
    logic         have;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W:0]   exp_v;
    logic [W:0]   popped;
    logic [W-1:0] hold_sum;
    logic [31:0]  rnd;
    sent = 0; got = 0; cyc = 0; have = 1'b0; hold_sum = '0; exp_v = '0;
    while (got < n_items && cyc < n_items * 8 + 100) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= 8 && cyc <= 12);
        default: out_ready = ($urandom_range(0, 1) != 0);
      endcase
      if (!have && sent < n_items) begin
        if (sent < 10) begin
          a = va[sent]; b = vb[sent]; c = vc[sent]; exp_v = ve[sent];
        end else begin
          rnd = $urandom(); a = rnd[W-1:0];
          rnd = $urandom(); b = rnd[W-1:0]; c = rnd[31];
          exp_v = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        end
        have = (mode == 2) ? ($urandom_range(0, 1) != 0) : 1'b1;
      end
      set_ab(a, b, c);
      in_valid = have;
      #1;
      if (mode == 0) begin
        check({tag, "_inrdy"}, in_ready, 1);
        if (cyc >= 3) check({tag, "_rate"}, out_valid, 1);
      end
      if (mode == 1 && cyc >= 8 && cyc <= 12) begin
        if (cyc == 8) hold_sum = sum;
        else check({tag, "_stall_sum"}, sum, hold_sum);
        check({tag, "_stall_vld"}, out_valid, 1);
`ifdef CPA_PREFIX_SKID_EN
        check({tag, "_stall_inrdy"}, in_ready, (cyc == 8) ? 1 : 0);
`else
        check({tag, "_stall_inrdy"}, in_ready, 0);
`endif
      end
      if (out_valid && out_ready) begin
        check({tag, "_q_nonempty"}, (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          popped = sb_q.pop_front();
          check({tag, "_sum"}, sum, popped[W-1:0]);
          check({tag, "_cout"}, cout, popped[W]);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(exp_v);
        sent++;
        have = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_done"}, got, n_items);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    g = '0; p = '0; cin = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);

    single_op("carry_chain", 17'h1FFFF, 17'h00001, 1'b0, 18'h20000);
    single_op("cin_only_1", 17'h00000, 17'h1FFFF, 1'b1, 18'h20000);
    single_op("cin_only_0", 17'h00000, 17'h1FFFF, 1'b0, 18'h1FFFF);
    single_op("mixed", 17'h12345, 17'h0ABCD, 1'b0, 18'h1CF12);

    run_stream("stream", 200, 0);
    run_stream("bp", 40, 1);
    run_stream("rnd", 200, 2);

    // Reset with three items in flight
    out_ready = 1'b1;
    for (int i = 3; i < 6; i++) begin
      set_ab(va[i], vb[i], vc[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("postrst_no_stale", out_valid, 0);
    end

    single_op("after_rst", 17'h1AAAA, 17'h15555, 1'b0, 18'h2FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
